// File: rtl/intpol2_d4_fifo_out_iq_if.sv
// I/Q output FIFO bus: core-side write port, consumer-side read port and status flags.
interface intpol2_d4_fifo_out_iq_if #(
  parameter int DATAPATH_WIDTH = 12,
  parameter int ADDR_WIDTH     = 4
);
  logic                             clear;
  logic                             wr_en;
  logic signed [DATAPATH_WIDTH-1:0] I_in;
  logic signed [DATAPATH_WIDTH-1:0] Q_in;
  logic                             rd_en;
  logic signed [DATAPATH_WIDTH-1:0] I_out;
  logic signed [DATAPATH_WIDTH-1:0] Q_out;
  logic                             valid_o;
  logic                             Empty_o;
  logic                             Full_o;
  logic                             Afull_o;
  logic [ADDR_WIDTH:0]              count_o;
  logic                             overflow_o;
  logic                             underflow_o;

  modport master (
    output clear, wr_en, I_in, Q_in, rd_en,
    input  I_out, Q_out, valid_o, Empty_o, Full_o, Afull_o, count_o, overflow_o, underflow_o
  );

  modport slave (
    input  clear, wr_en, I_in, Q_in, rd_en,
    output I_out, Q_out, valid_o, Empty_o, Full_o, Afull_o, count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/intpol2_d4_fifo_out_iq.sv
// Dual-channel I/Q output FIFO behind the quadratic interpolator; registered read port,
// occupancy counter with empty/full/almost-full decodes and sticky over/underflow flags.
module intpol2_d4_fifo_out_iq #(
  parameter int DATAPATH_WIDTH = 12,
  parameter int ADDR_WIDTH     = 4,
  parameter int AFULL_MARGIN   = 4
) (
  input logic                   clk,
  input logic                   rstn,
  intpol2_d4_fifo_out_iq_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int DW    = DATAPATH_WIDTH;

  logic [2*DW-1:0]     mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic signed [DW-1:0]  i_q, q_q;
  logic                  vld, ovf, unf;
  logic                  empty, full, rd_acc, wr_acc;

  assign empty  = (count == '0);
  assign full   = (count == (ADDR_WIDTH+1)'(DEPTH));
  // Full implies non-empty, so a concurrent read always frees the slot being written.
  assign rd_acc = bus.rd_en & ~empty;
  assign wr_acc = bus.wr_en & (~full | rd_acc);

  // Storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_acc && !bus.clear) mem[wr_ptr] <= {bus.I_in, bus.Q_in};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      i_q    <= '0;
      q_q    <= '0;
      vld    <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      vld <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
        i_q    <= mem[rd_ptr][2*DW-1:DW];
        q_q    <= mem[rd_ptr][DW-1:0];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.wr_en && !wr_acc) ovf <= 1'b1;
      if (bus.rd_en && !rd_acc) unf <= 1'b1;
    end
  end

  assign bus.I_out       = i_q;
  assign bus.Q_out       = q_q;
  assign bus.valid_o     = vld;
  assign bus.Empty_o     = empty;
  assign bus.Full_o      = full;
  assign bus.Afull_o     = (count >= (ADDR_WIDTH+1)'(DEPTH - AFULL_MARGIN));
  assign bus.count_o     = count;
  assign bus.overflow_o  = ovf;
  assign bus.underflow_o = unf;
endmodule

// File: tb/tb_intpol2_d4_fifo_out_iq.sv
// Scoreboard bench for the I/Q output FIFO: queue-based reference model, decoupled read monitor.
module tb_intpol2_d4_fifo_out_iq;
  localparam int DW = 12, AW = 4, AM = 4, DEPTH = 16;

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  intpol2_d4_fifo_out_iq_if #(.DATAPATH_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  intpol2_d4_fifo_out_iq #(.DATAPATH_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_MARGIN(AM))
    dut (.clk(clk), .rstn(rstn), .bus(bus));

  int checks = 0, passed = 0;
  logic [2*DW-1:0] mq[$];   // model FIFO contents
  logic [2*DW-1:0] exp[$];  // expected read responses
  bit m_ovf = 0, m_unf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
  endtask

  // Monitor: every presented read pair must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rstn && bus.valid_o === 1'b1) begin
      if (exp.size() == 0) chk("spurious_valid", 1, 0);
      else chk("read_data", {8'h0, bus.I_out, bus.Q_out}, {8'h0, exp.pop_front()});
    end
  end

  task automatic check_flags(input string tag);
    int n = mq.size();
    chk({tag, ":count"}, 32'(bus.count_o), n);
    chk({tag, ":empty"}, 32'(bus.Empty_o), 32'(n == 0));
    chk({tag, ":full"},  32'(bus.Full_o),  32'(n == DEPTH));
    chk({tag, ":afull"}, 32'(bus.Afull_o), 32'(n >= DEPTH - AM));
    chk({tag, ":ovf"},   32'(bus.overflow_o),  32'(m_ovf));
    chk({tag, ":unf"},   32'(bus.underflow_o), 32'(m_unf));
  endtask

  // One clock: inputs driven at negedge, model stepped at the edge, flags checked at next negedge.
  task automatic cycle(input bit wr, input logic [DW-1:0] i, input logic [DW-1:0] q,
                       input bit rd, input bit clr, input string tag);
    bit rd_ok, wr_ok;
    bus.wr_en = wr; bus.I_in = i; bus.Q_in = q; bus.rd_en = rd; bus.clear = clr;
    @(posedge clk);
    if (clr) begin
      mq.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      rd_ok = rd && mq.size() > 0;
      wr_ok = wr && (mq.size() < DEPTH || rd_ok);
      if (rd_ok) exp.push_back(mq.pop_front());
      if (wr_ok) mq.push_back({i, q});
      if (wr && !wr_ok) m_ovf = 1;
      if (rd && !rd_ok) m_unf = 1;
    end
    @(negedge clk);
    bus.wr_en = 0; bus.rd_en = 0; bus.clear = 0;
    check_flags(tag);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ":count"}, 32'(bus.count_o), 0);
    chk({tag, ":empty"}, 32'(bus.Empty_o), 1);
    chk({tag, ":fl"}, {26'h0, bus.Full_o, bus.Afull_o, bus.valid_o, bus.overflow_o, bus.underflow_o, 1'b0}, 0);
    chk({tag, ":iq"}, {8'h0, bus.I_out, bus.Q_out}, 0);
  endtask

  initial begin
    logic [DW-1:0] di, dq;
    bus.clear = 0; bus.wr_en = 0; bus.rd_en = 0; bus.I_in = '0; bus.Q_in = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rstn = 1'b1;
    @(negedge clk);
    check_reset_state("idle");

    cycle(0, 0, 0, 1, 0, "rd_empty");          // underflow, no valid
    cycle(0, 0, 0, 0, 1, "clear0");

    for (int k = 0; k < DEPTH; k++) cycle(1, DW'(k), DW'(-k), 0, 0, "fill");
    cycle(1, 12'h7FF, 12'h7FF, 0, 0, "ovf_wr");
    for (int k = 0; k < DEPTH; k++) cycle(0, 0, 0, 1, 0, "drain");

    cycle(0, 0, 0, 0, 1, "clear1");
    for (int k = 0; k < DEPTH; k++) cycle(1, DW'(k + 100), DW'(k * 3), 0, 0, "fill2");
    cycle(1, 12'h555, 12'hAAA, 1, 0, "full_both");
    for (int k = 0; k < DEPTH; k++) cycle(0, 0, 0, 1, 0, "drain2");
    cycle(1, 12'h123, 12'h876, 1, 0, "empty_both");
    cycle(0, 0, 0, 1, 0, "read_single");

    cycle(0, 0, 0, 0, 1, "clear2");
    for (int k = 0; k < 40; k++) begin
      di = DW'($urandom); dq = DW'($urandom);
      cycle(k % 2 == 0, di, dq, k % 2 == 1, 0, "wrap");
    end

    for (int k = 0; k < 400; k++) begin
      di = DW'($urandom); dq = DW'($urandom);
      cycle($urandom_range(0, 99) < 55, di, dq, $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) == 0, "rand");
    end

    cycle(0, 0, 0, 0, 1, "clear3");
    cycle(0, 0, 0, 1, 0, "set_unf");
    for (int k = 0; k < 7; k++) cycle(1, DW'(k + 7), DW'(k), 0, 0, "to7");
    cycle(1, 12'h3C3, 12'h3C3, 1, 1, "clear_wr");
    cycle(0, 0, 0, 1, 0, "after_clear");      // must underflow: clear dropped the write

    for (int k = 0; k < 5; k++) cycle(1, DW'($urandom), DW'($urandom), k > 2, 0, "pre_rst");
    #2 rstn = 1'b0;
    #1 check_reset_state("async_rst");
    mq.delete(); m_ovf = 0; m_unf = 0;
    @(negedge clk);
    rstn = 1'b1;
    cycle(0, 0, 0, 0, 0, "post_rst");
    cycle(1, 12'h0F0, 12'h00F, 0, 0, "post_rst_wr");
    cycle(0, 0, 0, 1, 0, "post_rst_rd");

    repeat (2) @(negedge clk);
    chk("pending_reads", exp.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
